// File: rtl/vga_overlay_pkg.sv
// Shared constants for the full-screen overlay: FSM state codes, fade level range, dither matrix.
// Latency: n/a (constants and a pure lookup function).
// Backpressure: n/a.
package vga_overlay_pkg;

   // Number of fade steps between transparent and fully opaque
   localparam int FADE_LEVELS = 16;
   // Level spans 0..16 inclusive, so it needs one bit more than the step index
   localparam int LEVEL_W     = $clog2(FADE_LEVELS + 1);

   // Overlay controller states
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_FADE_IN  = 3'd1;
   localparam logic [2:0] ST_HOLD     = 3'd2;
   localparam logic [2:0] ST_LATCHED  = 3'd3;
   localparam logic [2:0] ST_FADE_OUT = 3'd4;

   // 4x4 ordered-dither thresholds, row-major, indexed by {y[1:0], x[1:0]}
   localparam logic [3:0] BAYER_THR [16] = '{
      4'd0,  4'd8,  4'd2,  4'd10,
      4'd12, 4'd4,  4'd14, 4'd6,
      4'd3,  4'd11, 4'd1,  4'd9,
      4'd15, 4'd7,  4'd13, 4'd5
   };

   // Threshold for a pixel position inside its 4x4 tile
   function automatic logic [3:0] bayer_thr(input logic [1:0] y, input logic [1:0] x);
      return BAYER_THR[{y, x}];
   endfunction

endpackage

// File: rtl/overlay_dither_cmp.sv
// Decides whether one pixel is covered by the overlay at the given fade level (ordered dither).
// Latency: combinational.
// Backpressure: none.
module overlay_dither_cmp
   import vga_overlay_pkg::*;
(
   input  logic [1:0]         pixelX,
   input  logic [1:0]         pixelY,
   input  logic [LEVEL_W-1:0] level,
   output logic               covered
);

   // A pixel is covered once the level exceeds its tile threshold: level 0 covers none, 16 covers all
   always_comb begin
      covered = ({1'b0, bayer_thr(pixelY, pixelX)} < level);
   end

endmodule

// File: rtl/screen_overlay_fsm.sv
// Full-screen overlay layer with frame-counted hold and optional dithered fade, timed and latched triggers.
// Latency: overlayDrawingRequest is registered, one clock after the pixel inputs.
// Backpressure: none; a pixel-rate stream, only startOfFrame pulses advance the timers.
module screen_overlay_fsm
   import vga_overlay_pkg::*;
#(
   parameter logic [7:0] OVERLAY_COLOR    = 8'h00,
   parameter int         HOLD_FRAMES      = 120,
   parameter bit         FADE_EN          = 1'b1,
   parameter int         FADE_STEP_FRAMES = 2,
   parameter bit         RETRIGGER_EN     = 1'b1
)(
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic        insideRectangle,
   input  logic        trigTimed,
   input  logic        trigLatched,
   output logic        overlayDrawingRequest,
   output logic [7:0]  overlayRGB,
   output logic        busy,
   output logic        opaque
);

   localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
   localparam int STEP_W = $clog2(FADE_STEP_FRAMES + 1);

   localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_FRAMES);
   localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
   localparam logic [STEP_W-1:0]  STEP_LOAD  = STEP_W'(FADE_STEP_FRAMES);
   localparam logic [STEP_W-1:0]  STEP_ONE   = STEP_W'(1);
   localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(FADE_LEVELS);
   localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);

   logic [2:0]         state, state_nxt;
   logic [LEVEL_W-1:0] level, level_nxt;
   logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
   logic [STEP_W-1:0]  step_cnt, step_nxt;
   logic               trig_prev;
   logic               trig_rise;
   logic               step_due;
   logic               covered;
   logic               unused_pix_bits;

   // Only the low two coordinate bits select a dither threshold
   assign unused_pix_bits = ^{pixelX[10:2], pixelY[10:2]};

   assign trig_rise  = trigTimed & ~trig_prev;
   assign step_due   = startOfFrame && (step_cnt <= STEP_ONE);
   assign busy       = (state != ST_IDLE);
   assign opaque     = (state == ST_HOLD) || (state == ST_LATCHED);
   assign overlayRGB = OVERLAY_COLOR;

   overlay_dither_cmp u_dither (
      .pixelX  (pixelX[1:0]),
      .pixelY  (pixelY[1:0]),
      .level   (level),
      .covered (covered)
   );

   // Next-state, fade level and frame counters; latched trigger wins over the timed edge
   always_comb begin
      state_nxt = state;
      level_nxt = level;
      hold_nxt  = hold_cnt;
      step_nxt  = step_cnt;
      case (state)
         ST_IDLE: begin
            if (trigLatched) begin
               if (FADE_EN) begin
                  state_nxt = ST_FADE_IN;
                  step_nxt  = STEP_LOAD;
               end else begin
                  state_nxt = ST_LATCHED;
                  level_nxt = LEVEL_FULL;
               end
            end else if (trig_rise) begin
               if (FADE_EN) begin
                  state_nxt = ST_FADE_IN;
                  step_nxt  = STEP_LOAD;
               end else begin
                  state_nxt = ST_HOLD;
                  level_nxt = LEVEL_FULL;
                  hold_nxt  = HOLD_LOAD;
               end
            end
         end
         ST_FADE_IN: begin
            // Checked before stepping so a reversal that starts at full level settles at once
            if (level >= LEVEL_FULL) begin
               state_nxt = trigLatched ? ST_LATCHED : ST_HOLD;
               hold_nxt  = HOLD_LOAD;
            end else if (startOfFrame) begin
               if (step_due) begin
                  level_nxt = level + LEVEL_ONE;
                  step_nxt  = STEP_LOAD;
               end else begin
                  step_nxt  = step_cnt - STEP_ONE;
               end
            end
         end
         ST_HOLD: begin
            if (trigLatched) begin
               state_nxt = ST_LATCHED;
            end else if (trig_rise && RETRIGGER_EN) begin
               hold_nxt  = HOLD_LOAD;
            end else if (startOfFrame) begin
               if (hold_cnt <= HOLD_ONE) begin
                  hold_nxt = '0;
                  if (FADE_EN) begin
                     state_nxt = ST_FADE_OUT;
                     step_nxt  = STEP_LOAD;
                  end else begin
                     state_nxt = ST_IDLE;
                     level_nxt = '0;
                  end
               end else begin
                  hold_nxt = hold_cnt - HOLD_ONE;
               end
            end
         end
         ST_LATCHED: begin
            level_nxt = LEVEL_FULL;
            if (!trigLatched) begin
               if (FADE_EN) begin
                  state_nxt = ST_FADE_OUT;
                  step_nxt  = STEP_LOAD;
               end else begin
                  state_nxt = ST_IDLE;
                  level_nxt = '0;
               end
            end
         end
         ST_FADE_OUT: begin
            // A new trigger reverses direction from the current level, no jump
            if (trigLatched || trig_rise) begin
               state_nxt = ST_FADE_IN;
               step_nxt  = STEP_LOAD;
            end else if (startOfFrame) begin
               if (step_due) begin
                  step_nxt = STEP_LOAD;
                  if (level <= LEVEL_ONE) begin
                     level_nxt = '0;
                     state_nxt = ST_IDLE;
                  end else begin
                     level_nxt = level - LEVEL_ONE;
                  end
               end else begin
                  step_nxt = step_cnt - STEP_ONE;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            level_nxt = '0;
            hold_nxt  = '0;
            step_nxt  = '0;
         end
      endcase
   end

   // State, counters, trigger edge history and the registered drawing request
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state                 <= ST_IDLE;
         level                 <= '0;
         hold_cnt              <= '0;
         step_cnt              <= '0;
         trig_prev             <= 1'b0;
         overlayDrawingRequest <= 1'b0;
      end else begin
         state                 <= state_nxt;
         level                 <= level_nxt;
         hold_cnt              <= hold_nxt;
         step_cnt              <= step_nxt;
         trig_prev             <= trigTimed;
         overlayDrawingRequest <= insideRectangle & covered & busy;
      end
   end

endmodule

// File: tb/tb_screen_overlay_fsm.sv
// Directed bench for screen_overlay_fsm: three parameterisations driven by shared stimulus.
// Latency: request sampled one clock after the pixel it belongs to.
// Backpressure: none.
module tb_screen_overlay_fsm;

   logic        clk;
   logic        resetN;
   logic        startOfFrame;
   logic [10:0] pixelX;
   logic [10:0] pixelY;
   logic        insideRectangle;
   logic        trigTimed;
   logic        trigLatched;

   logic       req_h, busy_h, opq_h;
   logic [7:0] rgb_h;
   logic       req_f, busy_f, opq_f;
   logic [7:0] rgb_f;
   logic       req_n, busy_n, opq_n;
   logic [7:0] rgb_n;

   int n_tests = 0;
   int n_fail  = 0;

   // Hard on/off, hold 3 frames, retrigger enabled
   screen_overlay_fsm #(.OVERLAY_COLOR(8'h00), .HOLD_FRAMES(3), .FADE_EN(1'b0),
                        .FADE_STEP_FRAMES(1), .RETRIGGER_EN(1'b1)) u_hard (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pixelX(pixelX), .pixelY(pixelY),
      .insideRectangle(insideRectangle), .trigTimed(trigTimed), .trigLatched(trigLatched),
      .overlayDrawingRequest(req_h), .overlayRGB(rgb_h), .busy(busy_h), .opaque(opq_h));

   // Dithered fade, one frame per level, hold 3 frames
   screen_overlay_fsm #(.OVERLAY_COLOR(8'hE0), .HOLD_FRAMES(3), .FADE_EN(1'b1),
                        .FADE_STEP_FRAMES(1), .RETRIGGER_EN(1'b1)) u_fade (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pixelX(pixelX), .pixelY(pixelY),
      .insideRectangle(insideRectangle), .trigTimed(trigTimed), .trigLatched(trigLatched),
      .overlayDrawingRequest(req_f), .overlayRGB(rgb_f), .busy(busy_f), .opaque(opq_f));

   // Hard on/off, hold 3 frames, retrigger disabled
   screen_overlay_fsm #(.OVERLAY_COLOR(8'h1C), .HOLD_FRAMES(3), .FADE_EN(1'b0),
                        .FADE_STEP_FRAMES(2), .RETRIGGER_EN(1'b0)) u_nort (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pixelX(pixelX), .pixelY(pixelY),
      .insideRectangle(insideRectangle), .trigTimed(trigTimed), .trigLatched(trigLatched),
      .overlayDrawingRequest(req_n), .overlayRGB(rgb_n), .busy(busy_n), .opaque(opq_n));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-frame expectations for the fade profile run (index = frames since trigger)
   typedef struct {
      int lvl_f;
      int busy_f;
      int opq_f;
      int cov_h;
      int busy_h;
      int opq_h;
   } vec_t;

   vec_t tbl [36];

   function automatic vec_t mk(input int lf, input int bf, input int of,
                               input int ch, input int bh, input int oh);
      vec_t v;
      v.lvl_f = lf; v.busy_f = bf; v.opq_f = of;
      v.cov_h = ch; v.busy_h = bh; v.opq_h = oh;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
   endtask

   task automatic pulse_timed();
      trigTimed = 1'b1;
      tick();
      trigTimed = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      trigTimed = 1'b0; trigLatched = 1'b0; startOfFrame = 1'b0;
      insideRectangle = 1'b1; pixelX = '0; pixelY = '0;
      #2 resetN = 1'b0;
      tick();
      #3 resetN = 1'b1;
      tick();
   endtask

   // Sweep one 4x4 tile and count covered pixels for each instance
   task automatic measure(output int ch, output int cf, output int cn);
      ch = 0; cf = 0; cn = 0;
      insideRectangle = 1'b1;
      for (int i = 0; i < 16; i++) begin
         pixelX = 11'(i % 4);
         pixelY = 11'(i / 4);
         tick();
         ch += int'(req_h);
         cf += int'(req_f);
         cn += int'(req_n);
      end
   endtask

   task automatic probe_f(input int x, input int y, output int r);
      pixelX = 11'(x);
      pixelY = 11'(y);
      tick();
      r = int'(req_f);
   endtask

   initial begin
      int ch, cf, cn, p00, p10;

      // Fade profile table: fade level rises 1/frame, holds 3 frames, falls 1/frame.
      // The hard instance holds for 3 frames then drops.
      tbl[0]  = mk(0, 1,0, 16,1,1);  tbl[1]  = mk(1, 1,0, 16,1,1);  tbl[2]  = mk(2, 1,0, 16,1,1);
      tbl[3]  = mk(3, 1,0, 0,0,0);   tbl[4]  = mk(4, 1,0, 0,0,0);   tbl[5]  = mk(5, 1,0, 0,0,0);
      tbl[6]  = mk(6, 1,0, 0,0,0);   tbl[7]  = mk(7, 1,0, 0,0,0);   tbl[8]  = mk(8, 1,0, 0,0,0);
      tbl[9]  = mk(9, 1,0, 0,0,0);   tbl[10] = mk(10,1,0, 0,0,0);   tbl[11] = mk(11,1,0, 0,0,0);
      tbl[12] = mk(12,1,0, 0,0,0);   tbl[13] = mk(13,1,0, 0,0,0);   tbl[14] = mk(14,1,0, 0,0,0);
      tbl[15] = mk(15,1,0, 0,0,0);   tbl[16] = mk(16,1,1, 0,0,0);   tbl[17] = mk(16,1,1, 0,0,0);
      tbl[18] = mk(16,1,1, 0,0,0);   tbl[19] = mk(16,1,0, 0,0,0);   tbl[20] = mk(15,1,0, 0,0,0);
      tbl[21] = mk(14,1,0, 0,0,0);   tbl[22] = mk(13,1,0, 0,0,0);   tbl[23] = mk(12,1,0, 0,0,0);
      tbl[24] = mk(11,1,0, 0,0,0);   tbl[25] = mk(10,1,0, 0,0,0);   tbl[26] = mk(9, 1,0, 0,0,0);
      tbl[27] = mk(8, 1,0, 0,0,0);   tbl[28] = mk(7, 1,0, 0,0,0);   tbl[29] = mk(6, 1,0, 0,0,0);
      tbl[30] = mk(5, 1,0, 0,0,0);   tbl[31] = mk(4, 1,0, 0,0,0);   tbl[32] = mk(3, 1,0, 0,0,0);
      tbl[33] = mk(2, 1,0, 0,0,0);   tbl[34] = mk(1, 1,0, 0,0,0);   tbl[35] = mk(0, 0,0, 0,0,0);

      // Reset state
      resetN = 1'b0;
      trigTimed = 1'b0; trigLatched = 1'b0; startOfFrame = 1'b0;
      insideRectangle = 1'b1; pixelX = '0; pixelY = '0;
      tick();
      chk("rst req_h", int'(req_h), 0);   chk("rst busy_h", int'(busy_h), 0); chk("rst opq_h", int'(opq_h), 0);
      chk("rst req_f", int'(req_f), 0);   chk("rst busy_f", int'(busy_f), 0); chk("rst opq_f", int'(opq_f), 0);
      chk("rst busy_n", int'(busy_n), 0);
      chk("rgb_h", int'(rgb_h), 'h00); chk("rgb_f", int'(rgb_f), 'hE0); chk("rgb_n", int'(rgb_n), 'h1C);
      #3 resetN = 1'b1;
      tick();

      // Hard timed overlay and fade profile, table driven
      do_reset();
      measure(ch, cf, cn);
      chk("idle cov_h", ch, 0);
      chk("idle cov_f", cf, 0);
      trigTimed = 1'b1;
      tick();
      trigTimed = 1'b0;
      for (int f = 0; f < 36; f++) begin
         if (f > 0) frame();
         measure(ch, cf, cn);
         probe_f(0, 0, p00);
         probe_f(1, 0, p10);
         chk($sformatf("t2 cov_f f%0d", f), cf, tbl[f].lvl_f);
         chk($sformatf("t2 busy_f f%0d", f), int'(busy_f), tbl[f].busy_f);
         chk($sformatf("t2 opq_f f%0d", f), int'(opq_f), tbl[f].opq_f);
         chk($sformatf("t2 pix00 f%0d", f), p00, (tbl[f].lvl_f > 0) ? 1 : 0);
         chk($sformatf("t2 pix10 f%0d", f), p10, (tbl[f].lvl_f > 8) ? 1 : 0);
         chk($sformatf("t1 cov_h f%0d", f), ch, tbl[f].cov_h);
         chk($sformatf("t1 busy_h f%0d", f), int'(busy_h), tbl[f].busy_h);
         chk($sformatf("t1 opq_h f%0d", f), int'(opq_h), tbl[f].opq_h);
      end

      // Latched priority: both triggers in one cycle, held 500 frames
      do_reset();
      trigTimed = 1'b1; trigLatched = 1'b1;
      tick();
      trigTimed = 1'b0;
      tick();
      chk("t3 opq_h start", int'(opq_h), 1);
      for (int f = 1; f <= 500; f++) begin
         frame();
         if (f % 100 == 0) chk($sformatf("t3 opq_h f%0d", f), int'(opq_h), 1);
      end
      measure(ch, cf, cn);
      chk("t3 cov_h held", ch, 16);
      chk("t3 cov_f held", cf, 16);
      chk("t3 opq_f held", int'(opq_f), 1);
      trigLatched = 1'b0;
      tick();
      chk("t3 busy_h release", int'(busy_h), 0);
      chk("t3 busy_f release", int'(busy_f), 1);
      chk("t3 opq_f release", int'(opq_f), 0);
      for (int f = 0; f < 15; f++) frame();
      measure(ch, cf, cn);
      chk("t3 cov_f lvl1", cf, 1);
      chk("t3 busy_f lvl1", int'(busy_f), 1);
      frame();
      measure(ch, cf, cn);
      chk("t3 cov_f idle", cf, 0);
      chk("t3 busy_f idle", int'(busy_f), 0);

      // Retrigger at hold count 1
      do_reset();
      pulse_timed();
      frame();
      frame();
      chk("t4 busy_h cnt1", int'(busy_h), 1);
      chk("t4 busy_n cnt1", int'(busy_n), 1);
      pulse_timed();
      frame();
      chk("t4 busy_h +1", int'(busy_h), 1);
      chk("t4 busy_n +1", int'(busy_n), 0);
      frame();
      chk("t4 busy_h +2", int'(busy_h), 1);
      chk("t4 opq_h +2", int'(opq_h), 1);
      frame();
      chk("t4 busy_h +3", int'(busy_h), 0);

      // Reverse during fade-out at level 7
      do_reset();
      pulse_timed();
      for (int f = 0; f < 28; f++) frame();
      measure(ch, cf, cn);
      chk("t5 cov_f lvl7", cf, 7);
      chk("t5 opq_f lvl7", int'(opq_f), 0);
      pulse_timed();
      measure(ch, cf, cn);
      chk("t5 cov_f reversed", cf, 7);
      for (int k = 1; k <= 9; k++) begin
         frame();
         measure(ch, cf, cn);
         chk($sformatf("t5 cov_f k%0d", k), cf, 7 + k);
      end
      chk("t5 opq_f top", int'(opq_f), 1);

      // Asynchronous reset mid-HOLD
      do_reset();
      pulse_timed();
      insideRectangle = 1'b0;
      tick();
      chk("t6 req_h outside", int'(req_h), 0);
      insideRectangle = 1'b1;
      tick();
      chk("t6 req_h before", int'(req_h), 1);
      chk("t6 opq_h before", int'(opq_h), 1);
      #2 resetN = 1'b0;
      #1;
      chk("t6 req_h async", int'(req_h), 0);
      chk("t6 busy_h async", int'(busy_h), 0);
      chk("t6 opq_h async", int'(opq_h), 0);
      #3 resetN = 1'b1;
      tick();
      for (int f = 0; f < 4; f++) frame();
      measure(ch, cf, cn);
      chk("t6 cov_h after", ch, 0);
      chk("t6 busy_h after", int'(busy_h), 0);
      pulse_timed();
      chk("t6 busy_h retrig", int'(busy_h), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/screen_overlay_fsm.md
Name: screen_overlay_fsm

Overview:
- Parametrised full-screen overlay controller for the VGA path. Generalises the fixed black-screen blocker.
- Frame-counted timing (not clock cycles), optional ordered-dither fade-in/fade-out, and two trigger channels:
  - timed: level change;
  - latched: game over.
- Output feeds the object mux as one more drawing-request/RGB layer, above all game objects.

Parameters:
- OVERLAY_COLOR, 8'h00, RGB332 overlay colour.
- HOLD_FRAMES, 120, frames the timed overlay stays fully opaque (min 1).
- FADE_EN, 1, 1 = dithered fade in/out; 0 = hard on/off.
- FADE_STEP_FRAMES, 2, frames per fade level step (min 1).
- RETRIGGER_EN, 1, 1 = a timed trigger during HOLD reloads the hold counter.

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- pixelX  in  11  current pixel X
- pixelY  in  11  current pixel Y
- insideRectangle  in  1  pixel inside overlay region
- trigTimed  in  1  level; rising edge starts timed overlay
- trigLatched  in  1  level; overlay held while high
- overlayDrawingRequest  out  1  pixel must show overlay colour
- overlayRGB  out  8  overlay colour
- busy  out  1  state != IDLE
- opaque  out  1  state is HOLD or LATCHED (game logic may swap level here)

Behaviour:
- Reset (async, active-low): state IDLE, level 0, counters 0, edge register 0. overlayDrawingRequest=0, busy=0, opaque=0. overlayRGB is constant OVERLAY_COLOR.
- Reset mid-operation: same values, immediately; no fade-out.
- Edge detection:
  - trigTimed is registered; a rise is trigTimed & ~prev.
  - trigLatched is used as a level.
- States: IDLE, FADE_IN, HOLD, LATCHED, FADE_OUT.
- IDLE:
  - trigLatched → FADE_IN (FADE_EN=1) or LATCHED (FADE_EN=0).
  - Else rise of trigTimed → FADE_IN or HOLD.
  - Latched has priority when both occur in the same cycle.
- FADE_IN:
  - Each FADE_STEP_FRAMES startOfFrame pulses, level += 1.
  - When level reaches 16: go to LATCHED if trigLatched, else HOLD (hold counter = HOLD_FRAMES).
- HOLD:
  - On each startOfFrame, decrement the hold counter; at 0 → FADE_OUT (or IDLE with level=0 if FADE_EN=0).
  - trigLatched high → LATCHED next cycle.
  - Rise of trigTimed with RETRIGGER_EN=1 reloads HOLD_FRAMES.
- LATCHED:
  - Level fixed at 16.
  - On trigLatched low → FADE_OUT, or IDLE if FADE_EN=0.
- FADE_OUT:
  - Level -= 1 per FADE_STEP_FRAMES frames; at 0 → IDLE.
  - trigLatched high → FADE_IN from the current level.
  - Rise of trigTimed → FADE_IN from the current level.
- Frame counting: only startOfFrame pulses advance the step and hold counters. Clock cycles between frames are ignored.
- Dither:
  - threshold = 4x4 Bayer matrix indexed by {pixelY[1:0], pixelX[1:0]}, values 0..15. Row 0 is 0,8,2,10.
  - Pixel covered iff threshold < level.
  - Level width is 5 bits, range 0..16; 16 covers every pixel and 0 covers none.
- Output: overlayDrawingRequest is registered (1-cycle latency from pixel inputs) and equals insideRectangle & covered & busy.
- Counter widths: $clog2(HOLD_FRAMES+1) and $clog2(FADE_STEP_FRAMES+1). No wrap; counters saturate at 0.

Decomposition:
- Package vga_overlay_pkg holds:
  - the state enum;
  - FADE_LEVELS=16 and the level width constant;
  - the 16-entry Bayer threshold constant array.
- Sub-module overlay_dither_cmp: combinational; inputs pixelX[1:0], pixelY[1:0], level[4:0]; output covered.
- The FSM, frame counters and output register live in the top module.

Test Plan:
- Test 1, hard timed overlay (FADE_EN=0, HOLD_FRAMES=3):
  - Stimulus: pulse trigTimed, insideRectangle=1.
  - Response: request=1 on every pixel for exactly 3 frames; busy drops after the 3rd startOfFrame; opaque=1 throughout.
- Test 2, fade profile (FADE_EN=1, FADE_STEP_FRAMES=1):
  - Stimulus: rise of trigTimed.
  - Response: coverage per 4x4 tile rises 1/16 per frame to 16/16, holds HOLD_FRAMES, then falls to 0; pixel (0,0) on from level 1, pixel (1,0) from level 9.
- Test 3, latched priority:
  - Stimulus: trigTimed rise and trigLatched=1 in the same cycle.
  - Response: LATCHED reached; overlay stays opaque for 500 frames; after trigLatched falls, fade-out, then IDLE.
- Test 4, retrigger:
  - Stimulus: trigTimed rise at hold count 1 with RETRIGGER_EN=1.
  - Response: hold extends to HOLD_FRAMES more frames.
  - Same stimulus with RETRIGGER_EN=0: no extension.
- Test 5, reverse during fade-out:
  - Stimulus: trigTimed rise at level 7.
  - Response: level climbs 7→16, with no jump.
- Test 6, asynchronous reset:
  - Stimulus: resetN low mid-HOLD, between clock edges.
  - Response: request, busy and opaque are 0 immediately; after release, no overlay until a new trigger.
